// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer
// Second stage of the BIST chain. Catches each rising edge of the pattern
// generator's strobe clock and compresses the 4-bit pattern into a MISR
// (x^4+x+1). After PATTERN_COUNT patterns it compares the signature with
// GOLDEN and reports pass/fail on the LEDs.
module bist_response_analyzer #(
    parameter int         PATTERN_COUNT = 9,
    parameter logic [3:0] SEED          = 4'h0,
    parameter logic [3:0] GOLDEN        = 4'hE
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       sclk_in,
    input  logic [3:0] pattern,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [3:0] signature,
    output logic [3:0] led
);

    localparam int CW = $clog2(PATTERN_COUNT + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(PATTERN_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Strobe synchroniser and edge-history flops
    logic s1_q, s2_q, s3_q;
    logic stb;

    // Control and datapath state
    state_t        state_q, state_d;
    logic [3:0]    sig_q, sig_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic [3:0]    misr_next;

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sclk_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // One-cycle pulse per synchronised rising edge of sclk_in
    assign stb = s2_q & ~s3_q;

    // MISR next state: shift with feedback from bit 3 into taps 0 and 1
    always_comb begin
        misr_next[0] = sig_q[3] ^ pattern[0];
        misr_next[1] = sig_q[0] ^ sig_q[3] ^ pattern[1];
        misr_next[2] = sig_q[1] ^ pattern[2];
        misr_next[3] = sig_q[2] ^ pattern[3];
    end

    // Run control: next state, signature, pattern count and status outputs
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // start beats a coincident strobe; that strobe's pattern is dropped
                if (start) begin
                    state_d = ST_RUN;
                    sig_d   = SEED;
                    count_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            ST_RUN: begin
                // start is ignored here; only strobes advance the run
                if (stb) begin
                    sig_d   = misr_next;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_COUNT) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (misr_next == GOLDEN);
                        fail_d  = (misr_next != GOLDEN);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sig_d   = SEED;
                count_d = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                fail_d  = 1'b0;
            end
        endcase
    end

    // State register with registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign signature = sig_q;
    assign led       = {done_q, pass_q, fail_q, busy_q};

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Testbench for bist_response_analyzer: directed scenarios plus random runs.
// Expected final results are queued when a run is launched; a monitor pops
// and compares them whenever done rises.
module tb_bist_response_analyzer;

    logic       clk;
    logic       rst;
    logic       sclk_in;
    logic [3:0] pattern;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic [3:0] signature;
    logic [3:0] led;

    localparam logic [3:0] SEED   = 4'h0;
    localparam logic [3:0] GOLDEN = 4'hE;

    bist_response_analyzer #(
        .PATTERN_COUNT(9),
        .SEED         (SEED),
        .GOLDEN       (GOLDEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk_in  (sclk_in),
        .pattern  (pattern),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .signature(signature),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sig;
        logic       pass;
        logic       fail;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference MISR step: multiply by x modulo x^4+x+1, then add the pattern
    function automatic logic [3:0] model_step(input logic [3:0] s, input logic [3:0] d);
        int v;
        v = (int'(s) * 2) & 15;
        if (int'(s) >= 8) v = v ^ 3;
        v = v ^ int'(d);
        return v[3:0];
    endfunction

    // Monitor: each rising edge of done is one completed run
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with empty scoreboard at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                $display("run complete: signature=%0h pass=%0b fail=%0b led=%b", signature, pass, fail, led);
                check("final_signature", 32'(signature), 32'(e.sig));
                check("final_pass", 32'(pass), 32'(e.pass));
                check("final_fail", 32'(fail), 32'(e.fail));
                check("final_led", 32'(led), 32'({1'b1, e.pass, e.fail, 1'b0}));
            end
        end
        prev_done = done;
    end

    // One sclk_in period of 4 clk high + 4 clk low carrying pattern p
    task automatic send_pattern(input logic [3:0] p);
        @(negedge clk);
        pattern = p;
        sclk_in = 1'b1;
        repeat (4) @(negedge clk);
        sclk_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Same period, but start is raised exactly in the strobe cycle
    task automatic send_pattern_with_start(input logic [3:0] p);
        @(negedge clk);
        pattern = p;
        sclk_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        sclk_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feed nine patterns into a run already started; optionally poke start mid-run
    task automatic run_patterns(input logic [3:0] p[9], input int mid_start);
        logic [3:0] s;
        exp_t       e;
        s = SEED;
        for (int i = 0; i < 9; i++) s = model_step(s, p[i]);
        e.sig  = s;
        e.pass = (s == GOLDEN);
        e.fail = (s != GOLDEN);
        exp_q.push_back(e);
        s = SEED;
        for (int i = 0; i < 9; i++) begin
            send_pattern(p[i]);
            s = model_step(s, p[i]);
            check("step_signature", 32'(signature), 32'(s));
            if (i == mid_start) begin
                pulse_start();
                check("midrun_busy", 32'(busy), 32'd1);
                check("midrun_signature", 32'(signature), 32'(s));
            end
        end
    endtask

    logic [3:0] golden_seq [9];
    logic [3:0] fault_seq  [9];
    logic [3:0] zero_seq   [9];
    logic [3:0] rand_seq   [9];

    initial begin
        golden_seq = '{4'h8, 4'hC, 4'hE, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
        fault_seq  = '{4'h8, 4'hC, 4'hE, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
        zero_seq   = '{default: 4'h0};
        rst     = 1'b0;
        sclk_in = 1'b0;
        pattern = 4'h0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_led", 32'(led), 32'd0);
        check("reset_signature", 32'(signature), 32'(SEED));
        rst = 1'b1;

        // Strobes before start are ignored
        send_pattern(4'h8);
        send_pattern(4'h5);
        check("idle_signature", 32'(signature), 32'(SEED));
        check("idle_busy", 32'(busy), 32'd0);

        // Golden run with an ignored start pulse after the 4th pattern
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        run_patterns(golden_seq, 3);

        // Single-bit fault, restarted from DONE
        pulse_start();
        run_patterns(fault_seq, -1);

        // Stuck-at-zero CUT, then restart latency from DONE
        pulse_start();
        run_patterns(zero_seq, -1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_signature", 32'(signature), 32'(SEED));

        // Reset in the middle of the run started above
        for (int i = 0; i < 4; i++) send_pattern(golden_seq[i]);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_led", 32'(led), 32'd0);
        check("midreset_signature", 32'(signature), 32'(SEED));
        @(negedge clk);
        rst = 1'b1;
        pulse_start();
        run_patterns(golden_seq, -1);

        // start coincident with a strobe: that pattern is not compressed
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send_pattern_with_start(4'h7);
        check("coincident_busy", 32'(busy), 32'd1);
        check("coincident_signature", 32'(signature), 32'(SEED));
        run_patterns(golden_seq, -1);

        // Random runs against the reference model
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 9; i++) rand_seq[i] = 4'($urandom_range(0, 15));
            pulse_start();
            run_patterns(rand_seq, (r == 1) ? 5 : -1);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bist_response_analyzer.md
# bist_response_analyzer

- Downstream stage of the BIST pattern generator.
- Consumes the generator's 4-bit pattern and its divided strobe clock (sclk), both sampled in the fast `clk` domain.
- Compresses a fixed number of patterns into a 4-bit MISR signature, compares it with a golden value and reports pass/fail on the board LEDs.

## Interface

Parameters:
- PATTERN_COUNT, 9, patterns compressed per run (one full generator period); must be ≥1
- SEED, 4'h0, MISR value loaded at run start
- GOLDEN, 4'hE, expected final signature

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock; all state clocked on rising edge
- rst  input  1  asynchronous active-low reset
- sclk_in  input  1  generator's divided clock, asynchronous to this block's sampling
- pattern  input  4  generator pattern output, updated on sclk_in rise
- start  input  1  run request, sampled per clk
- busy  output  1  high while in RUN
- done  output  1  high in DONE, held until next start or reset
- pass  output  1  valid only with done; signature == GOLDEN
- fail  output  1  valid only with done; signature != GOLDEN
- signature  output  4  current MISR contents
- led  output  4  {done, pass, fail, busy}

## Operation

- Strobe path:
  - sclk_in passes through two sync flops s1, s2, then history flop s3.
  - stb = s2 & ~s3, i.e. exactly one clk cycle per sclk_in rising edge.
- MISR update (on stb in RUN only), with s = signature and d = pattern:
  - n0 = s3^d0
  - n1 = s0^s3^d1
  - n2 = s1^d2
  - n3 = s2^d3
  - Polynomial: x^4+x+1.
- Pattern counter: width $clog2(PATTERN_COUNT+1), unsigned, no wrap in normal use.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start → RUN; same edge loads signature=SEED and count=0.
  - RUN: busy=1. Each stb updates the MISR and increments count. The stb with count == PATTERN_COUNT-1 performs the final update and moves to DONE on the same edge.
  - DONE:
    - done=1; pass/fail registered on the DONE-entry edge from the final signature.
    - signature frozen.
    - start → RUN with SEED/count reload (restart allowed).
- start while in RUN is ignored; no abort.
- stb in IDLE or DONE is ignored; MISR unchanged.
- start and stb in the same cycle in IDLE/DONE: start wins. The MISR loads SEED, that stb is not compressed, and the first compressed pattern is the next stb.
- pass and fail are mutually exclusive and both 0 outside DONE.
- Reset, asserted anytime including mid-run, immediately forces:
  - state=IDLE, signature=SEED, count=0
  - s1=s2=s3=0
  - busy=done=pass=fail=0, led=4'b0000

## Timing

- sclk_in high and low phases must each be ≥3 clk periods. Narrower phases may drop strobes; this is not detected.
- stb latency: the stb cycle is 2 clk edges after the first clk edge that samples sclk_in high.
- pattern is sampled on the stb edge. It must be stable from the sclk_in rise until then, which holds because the generator updates only on sclk rise.
- start → busy=1 on the next clk edge (1-cycle latency).
- Final stb edge → busy=0, done=1, and pass/fail valid together after that edge.
- Run length: PATTERN_COUNT sclk periods plus ≤3 clk cycles.
- Reset deassertion is synchronised externally. The first start is honoured on the first clk edge with rst high.

## Test plan

- Golden run:
  - Stimulus: rst low then high, start pulse, then generator sequence 8,C,E,F,E,C,8,0,0 on 9 sclk_in rises.
  - Intermediate signatures: 8,F,3,9,F,1,A,7,E.
  - Final: signature=E, done=1, pass=1, fail=0, led=4'b1100.
- Single-bit fault: same sequence with the last pattern 1 instead of 0 → signature=F, fail=1, pass=0, led=4'b1010.
- Stuck-at-zero CUT: 9 patterns of 0 → signature=0, fail=1. Then assert start → busy=1, signature reloads 0, done=0 next cycle.
- Ignored events:
  - stb pulses before start → signature stays SEED, busy=0.
  - start pulse during RUN mid-way → count and signature not disturbed, final still E.
- Reset mid-run: drop rst after the 4th stb → all outputs 0 and signature=0 immediately (asynchronous). A fresh golden run afterwards ends with pass=1.
- start coincident with stb in IDLE: that pattern is excluded from compression. The following 9 patterns of the golden sequence give signature=E.
